// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// word geometry and a capacity helper.
package loader_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] ST_HDR   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  typedef enum logic [1:0] {
    HDR   = ST_HDR,
    LOAD  = ST_LOAD,
    DONE  = ST_DONE,
    ERROR = ST_ERROR
  } state_e;

  // Number of 32-bit words that fit in a BRAM with the given byte-address width.
  function automatic int unsigned capacity_words(input int addr_width);
    return 32'd1 << (addr_width - 2);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and BRAM write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [31:0]           mem_wr_data;
  logic [3:0]            mem_byte_w_en;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_wr_addr, mem_wr_data, mem_byte_w_en
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_wr_addr, mem_wr_data, mem_byte_w_en
  );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs little-endian stream bytes into 32-bit words; flags the byte that
// completes a word so the caller can register the write.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [31:0] shreg;
  logic [1:0]  byte_idx;

  // Right shift: after four bytes, byte 0 sits in [7:0] and byte 3 in [31:24].
  assign word      = {byte_in, shreg[31:8]};
  assign word_done = byte_valid && (byte_idx == 2'(WORD_BYTES - 1));

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (byte_valid) begin
      shreg    <= word;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Fills the instruction BRAM from a length-prefixed byte stream, holding the
// CPU in reset until the whole image has been written.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_BYTES  = 2
) (
  input  logic                  sysclk,
  input  logic                  rst,
  program_loader_if.slave       bus,
  input  logic                  reload,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int          LEN_W     = 8 * LEN_BYTES;
  localparam int          HDR_IDX_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam int unsigned CAPACITY  = capacity_words(ADDR_WIDTH);

  state_e                state, state_nxt;
  logic [LEN_W-1:0]      len, len_nxt;
  logic [HDR_IDX_W-1:0]  hdr_idx;
  logic [ADDR_WIDTH-2:0] word_idx;
  logic [3:0]            wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [31:0]           word;
  logic                  accept, hdr_last, asm_valid, word_done, restart, last_pulse;

  assign accept     = bus.rx_valid && bus.rx_ready;
  assign hdr_last   = (state == HDR) && accept && (hdr_idx == HDR_IDX_W'(LEN_BYTES - 1));
  assign asm_valid  = (state == LOAD) && accept;
  assign restart    = reload && ((state == DONE) || (state == ERROR));
  // Word index has already advanced past the final word when its pulse is out.
  assign last_pulse = (state == LOAD) && wr_en[0] && (32'(word_idx) == 32'(len));

  byte_assembler u_asm (
    .clk        (sysclk),
    .rst        (rst),
    .clear      (restart),
    .byte_valid (asm_valid),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_comb begin
    len_nxt = len;
    if ((state == HDR) && accept) len_nxt[int'(hdr_idx)*8 +: 8] = bus.rx_data;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    bus.rx_ready = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      HDR: begin
        bus.rx_ready = 1'b1;
        if (hdr_last) begin
          if (len_nxt == '0)                           state_nxt = DONE;
          else if (64'(len_nxt) > 64'(CAPACITY))       state_nxt = ERROR;
          else                                         state_nxt = LOAD;
        end
      end
      LOAD: begin
        bus.rx_ready = 1'b1;
        if (last_pulse) state_nxt = DONE;
      end
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (reload) state_nxt = HDR;
      end
      ERROR: begin
        error = 1'b1;
        if (reload) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= HDR;
      len      <= '0;
      hdr_idx  <= '0;
      word_idx <= '0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= '0;
      if (restart) begin
        len      <= '0;
        hdr_idx  <= '0;
        word_idx <= '0;
      end else begin
        if ((state == HDR) && accept) begin
          len     <= len_nxt;
          hdr_idx <= hdr_last ? '0 : hdr_idx + 1'b1;
        end
        if (asm_valid && word_done) begin
          wr_en    <= 4'hF;
          wr_addr  <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
          wr_data  <= word;
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  assign bus.mem_byte_w_en = wr_en;
  assign bus.mem_wr_addr   = wr_addr;
  assign bus.mem_wr_data   = wr_data;
  assign words_loaded      = word_idx;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// images, compared against a byte-stream reference model.
module tb_program_loader;

  localparam int AW  = 12;
  localparam int CAP = 1 << (AW - 2);

  logic          sysclk = 1'b0;
  logic          rst    = 1'b1;
  logic          reload = 1'b0;
  logic          cpu_rst, done, error;
  logic [AW-2:0] words_loaded;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .LEN_BYTES(2)) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .bus          (bus),
    .reload       (reload),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]    stim[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_done, exp_error;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            acc_cyc_q[$];
  int            done_rise_cyc, err_rise_cyc, bad_we;
  bit            done_prev, err_prev;

  // Observe every cycle just after the active edge.
  always @(posedge sysclk) begin
    #1;
    cyc++;
    if (bus.mem_byte_w_en !== 4'h0) begin
      if (bus.mem_byte_w_en !== 4'hF) bad_we++;
      wr_addr_q.push_back(bus.mem_wr_addr);
      wr_data_q.push_back(bus.mem_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if ((done === 1'b1) && !done_prev) done_rise_cyc = cyc;
    if ((error === 1'b1) && !err_prev) err_rise_cyc = cyc;
    done_prev = (done === 1'b1);
    err_prev  = (error === 1'b1);
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference model: what a BRAM image load of stim[0..n-1] must produce.
  task automatic model(input int n);
    int len;
    exp_addr.delete();
    exp_data.delete();
    len       = int'(stim[0]) + 256 * int'(stim[1]);
    exp_error = (len > CAP);
    if (!exp_error) begin
      for (int i = 0; i < len; i++) begin
        int b = 2 + 4 * i;
        if (b + 3 < n) begin
          exp_addr.push_back(AW'(i * 4));
          exp_data.push_back({stim[b+3], stim[b+2], stim[b+1], stim[b]});
        end
      end
    end
    exp_done = !exp_error && (exp_addr.size() == len);
  endtask

  function automatic int write_mismatches();
    int m = 0;
    if (wr_addr_q.size() != exp_addr.size()) m++;
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++)
      if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) m++;
    return m;
  endfunction

  // Each pulse must appear in the cycle right after its word's 4th byte is taken.
  function automatic int timing_mismatches();
    int m = 0;
    for (int i = 0; i < wr_cyc_q.size(); i++) begin
      int k = 2 + 4 * i + 3;
      if (k >= acc_cyc_q.size() || wr_cyc_q[i] != acc_cyc_q[k]) m++;
    end
    return m;
  endfunction

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
    done_rise_cyc = -1;
    err_rise_cyc  = -1;
    bad_we        = 0;
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge sysclk);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge sysclk);
    reload = 1'b0;
  endtask

  // Present one byte for up to budget cycles; ok reports whether it was taken.
  task automatic drive_byte(input logic [7:0] b, input int budget, output bit ok);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      if (bus.rx_ready === 1'b1) begin
        ok = 1'b1;
        acc_cyc_q.push_back(cyc + 1);
      end
      @(negedge sysclk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic drive_stream(input int lo, input int hi, input int gap_max, input int force_gap_at);
    bit ok;
    for (int i = lo; i < hi; i++) begin
      int gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (i == force_gap_at) gap += 3;
      repeat (gap) @(negedge sysclk);
      drive_byte(stim[i], 20, ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL rx_accept byte %0d not accepted within 20 cycles", i);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.rx_ready, cpu_rst, done, error} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_ctrl got ready/cpu_rst/done/error=%b want 1100",
               {bus.rx_ready, cpu_rst, done, error});
    end
    checks++;
    if ({bus.mem_byte_w_en, bus.mem_wr_addr, bus.mem_wr_data, words_loaded} !== '0) begin
      failures++;
      $display("FAIL reset_mem got we=%h addr=%h data=%h words=%0d want all zero",
               bus.mem_byte_w_en, bus.mem_wr_addr, bus.mem_wr_data, words_loaded);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    drive_stream(0, stim.size(), 0, -1);
    repeat (3) @(negedge sysclk);
    checks++;
    if (wr_addr_q.size() < 1 || wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'h00000013) begin
      failures++;
      $display("FAIL basic_w0 got %0d writes, want first 00000013@000", wr_addr_q.size());
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[1] !== 12'h004 || wr_data_q[1] !== 32'h00100093) begin
      failures++;
      $display("FAIL basic_w1 got %0d writes, want exactly 2 ending 00100093@004", wr_addr_q.size());
    end
    checks++;
    if (timing_mismatches() != 0) begin
      failures++;
      $display("FAIL basic_latency got %0d late/early pulses want 0", timing_mismatches());
    end
    checks++;
    if (wr_cyc_q.size() == 0 || done_rise_cyc != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
      failures++;
      $display("FAIL basic_release got done rise cycle %0d, want one after last pulse", done_rise_cyc);
    end
    checks++;
    if ({cpu_rst, done, error} !== 3'b010 || words_loaded !== 11'd2 || bad_we != 0) begin
      failures++;
      $display("FAIL basic_final got cpu_rst/done/error=%b words=%0d bad_we=%0d want 010 2 0",
               {cpu_rst, done, error}, words_loaded, bad_we);
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    model(stim.size());
    drive_stream(0, stim.size(), 3, 4);
    repeat (3) @(negedge sysclk);
    checks++;
    if (write_mismatches() != 0) begin
      failures++;
      $display("FAIL gapped_writes got %0d writes with %0d mismatches, want %0d exact",
               wr_addr_q.size(), write_mismatches(), exp_addr.size());
    end
    checks++;
    if (timing_mismatches() != 0) begin
      failures++;
      $display("FAIL gapped_latency got %0d mistimed pulses want 0", timing_mismatches());
    end
    checks++;
    if (done !== exp_done || words_loaded !== (AW-1)'(exp_addr.size())) begin
      failures++;
      $display("FAIL gapped_final got done=%b words=%0d want %b %0d",
               done, words_loaded, exp_done, exp_addr.size());
    end
  endtask

  task automatic test_zero_len();
    apply_reset();
    stim = {8'h00, 8'h00};
    drive_stream(0, 2, 0, -1);
    repeat (3) @(negedge sysclk);
    checks++;
    if (acc_cyc_q.size() != 2 || done_rise_cyc != acc_cyc_q[1]) begin
      failures++;
      $display("FAIL zero_release got done rise cycle %0d, want the cycle after the 2nd byte", done_rise_cyc);
    end
    checks++;
    if ({cpu_rst, done, error} !== 3'b010 || wr_addr_q.size() != 0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL zero_final got cpu_rst/done/error=%b writes=%0d words=%0d want 010 0 0",
               {cpu_rst, done, error}, wr_addr_q.size(), words_loaded);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    stim = {8'h01, 8'h04};
    drive_stream(0, 2, 0, -1);
    checks++;
    if (acc_cyc_q.size() != 2 || err_rise_cyc != acc_cyc_q[1]) begin
      failures++;
      $display("FAIL ovf_timing got error rise cycle %0d, want the cycle after the 2nd byte", err_rise_cyc);
    end
    checks++;
    if ({bus.rx_ready, cpu_rst, done, error} !== 4'b0101) begin
      failures++;
      $display("FAIL ovf_state got ready/cpu_rst/done/error=%b want 0101",
               {bus.rx_ready, cpu_rst, done, error});
    end
    drive_byte(8'h5A, 4, ok);
    checks++;
    if (ok || wr_addr_q.size() != 0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL ovf_blocked got accepted=%0d writes=%0d words=%0d want 0 0 0",
               ok, wr_addr_q.size(), words_loaded);
    end
    pulse_reload();
    checks++;
    if ({bus.rx_ready, cpu_rst, error} !== 3'b110) begin
      failures++;
      $display("FAIL ovf_reload got ready/cpu_rst/error=%b want 110", {bus.rx_ready, cpu_rst, error});
    end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    stim = {8'h03, 8'h00};
    repeat (6) stim.push_back(8'($urandom));
    model(stim.size());
    drive_stream(0, stim.size(), 0, -1);
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    checks++;
    if ({bus.rx_ready, cpu_rst, done, error, bus.mem_byte_w_en, bus.mem_wr_addr,
         bus.mem_wr_data, words_loaded} !== {4'b1100, 59'd0}) begin
      failures++;
      $display("FAIL midrst_values got ready/cpu_rst/done/error=%b we=%h addr=%h data=%h words=%0d want 1100 and zeros",
               {bus.rx_ready, cpu_rst, done, error}, bus.mem_byte_w_en, bus.mem_wr_addr,
               bus.mem_wr_data, words_loaded);
    end
    repeat (3) @(negedge sysclk);
    checks++;
    if (exp_addr.size() != 1 || write_mismatches() != 0) begin
      failures++;
      $display("FAIL midrst_writes got %0d writes want only word 0", wr_addr_q.size());
    end
    clear_obs();
    stim = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    drive_stream(0, stim.size(), 0, -1);
    repeat (3) @(negedge sysclk);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'hDDCCBBAA || done !== 1'b1) begin
      failures++;
      $display("FAIL midrst_fresh got %0d writes done=%b want DDCCBBAA@000 and done", wr_addr_q.size(), done);
    end
  endtask

  task automatic test_reload();
    apply_reset();
    stim = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    drive_stream(0, stim.size(), 0, -1);
    repeat (2) @(negedge sysclk);
    checks++;
    if (done !== 1'b1 || words_loaded !== 11'd1) begin
      failures++;
      $display("FAIL reload_pre got done=%b words=%0d want 1 1", done, words_loaded);
    end
    clear_obs();
    pulse_reload();
    checks++;
    if ({bus.rx_ready, cpu_rst, done} !== 3'b110 || words_loaded !== '0) begin
      failures++;
      $display("FAIL reload_restart got ready/cpu_rst/done=%b words=%0d want 110 0",
               {bus.rx_ready, cpu_rst, done}, words_loaded);
    end
    stim = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    drive_stream(0, 4, 0, -1);
    pulse_reload();
    checks++;
    if ({bus.rx_ready, cpu_rst, done} !== 3'b110) begin
      failures++;
      $display("FAIL reload_ignored got ready/cpu_rst/done=%b want 110", {bus.rx_ready, cpu_rst, done});
    end
    drive_stream(4, 6, 0, -1);
    repeat (3) @(negedge sysclk);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'hDEADBEEF ||
        cpu_rst !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL reload_load got %0d writes cpu_rst=%b done=%b want DEADBEEF@000 0 1",
               wr_addr_q.size(), cpu_rst, done);
    end
  endtask

  task automatic test_capacity();
    apply_reset();
    stim = {8'h00, 8'h04};
    repeat (4 * CAP) stim.push_back(8'($urandom));
    model(stim.size());
    drive_stream(0, stim.size(), 0, -1);
    repeat (3) @(negedge sysclk);
    checks++;
    if (write_mismatches() != 0 || timing_mismatches() != 0) begin
      failures++;
      $display("FAIL cap_writes got %0d writes, %0d data/addr and %0d timing mismatches want %0d exact",
               wr_addr_q.size(), write_mismatches(), timing_mismatches(), CAP);
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== 12'hFFC ||
        words_loaded !== 11'd1024 || done !== 1'b1) begin
      failures++;
      $display("FAIL cap_final got words=%0d done=%b want last addr FFC words 1024 done 1",
               words_loaded, done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len;
      if (it % 2 == 0) apply_reset();
      else begin
        clear_obs();
        pulse_reload();
      end
      len  = $urandom_range(1, 6);
      stim = {8'(len), 8'(len >> 8)};
      repeat (4 * len) stim.push_back(8'($urandom));
      model(stim.size());
      drive_stream(0, stim.size(), 2, -1);
      repeat (3) @(negedge sysclk);
      checks++;
      if (write_mismatches() != 0 || timing_mismatches() != 0 || bad_we != 0) begin
        failures++;
        $display("FAIL rand%0d_writes got %0d writes (%0d data, %0d timing, %0d enable errors) want %0d",
                 it, wr_addr_q.size(), write_mismatches(), timing_mismatches(), bad_we, exp_addr.size());
      end
      checks++;
      if (done !== exp_done || cpu_rst !== !exp_done || words_loaded !== (AW-1)'(exp_addr.size())) begin
        failures++;
        $display("FAIL rand%0d_final got done=%b cpu_rst=%b words=%0d want %b %b %0d",
                 it, done, cpu_rst, words_loaded, exp_done, !exp_done, exp_addr.size());
      end
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_gapped();
    test_zero_len();
    test_overflow();
    test_reset_mid_load();
    test_reload();
    test_capacity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time controller that fills the CPU's instruction BRAM from a byte stream, then releases the CPU core from reset. It sits between an external byte source (UART receiver or host bridge) and the write port of the program-memory `bram`, and drives the `rst` input of `cpu`. While it is loading, the CPU is held in reset and the loader owns the BRAM write port. Afterwards the loader is idle until a reload is requested.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: byte-address width of the program BRAM. Capacity is `2**(ADDR_WIDTH-2)` words.
- `LEN_BYTES`, 2: number of little-endian header bytes that carry the word count.

Ports:
- `sysclk` in 1: the single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: incoming stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte this cycle. A transfer occurs when `rx_valid && rx_ready`.
- `reload` in 1: single-cycle request to restart loading. Honoured only in DONE or ERROR.
- `mem_wr_addr` out `ADDR_WIDTH`: byte address for the BRAM write port. Always word-aligned; bits [1:0] = 0.
- `mem_wr_data` out 32: assembled instruction word.
- `mem_byte_w_en` out 4: byte write enables, either 4'b1111 or 4'b0000.
- `cpu_rst` out 1: reset to the CPU core, active-high.
- `done` out 1: the load completed successfully.
- `error` out 1: the header length exceeded capacity.
- `words_loaded` out `ADDR_WIDTH-1`: count of words written in the current load.

## Operation
States:
- **HDR**
  - Accepts `LEN_BYTES` bytes, LSB first, into `len`.
  - After the last header byte:
    - `len == 0` → DONE.
    - `len > 2**(ADDR_WIDTH-2)` → ERROR.
    - Otherwise → LOAD.
- **LOAD**
  - Accepts bytes little-endian into a 32-bit shift/assembly register: byte 0 goes to [7:0], byte 3 goes to [31:24].
  - On acceptance of byte 3 of a word, a write is registered for the next cycle.
  - After the write for word `len-1` is registered → DONE.
- **DONE**
  - `rx_ready` = 0.
  - `cpu_rst` = 0.
  - `done` = 1.
- **ERROR**
  - `rx_ready` = 0.
  - `cpu_rst` = 1.
  - `error` = 1.
  - No BRAM writes occur.
- `reload` in DONE or ERROR:
  - Next state is HDR.
  - Clears `done`, `error`, `words_loaded`, the byte index and the word index.
  - Reasserts `cpu_rst` in the following cycle.
  - `reload` in HDR or LOAD is ignored.
- Word `i` is written at `mem_wr_addr = i*4`. The word index must never wrap within a legal load.
- `words_loaded` increments on each write pulse. It holds its final value in DONE.
- `rx_ready` = 1 in HDR and LOAD. The loader never back-pressures inside a load.
- Bytes arriving in DONE or ERROR are not accepted.
- Gaps in `rx_valid` (any length, at any byte position) are tolerated. Partial-word state is held across gaps.

## Timing
- Reset values:
  - State = HDR.
  - `rx_ready` = 1.
  - `cpu_rst` = 1.
  - `done` = 0, `error` = 0.
  - `mem_byte_w_en` = 0, `mem_wr_addr` = 0, `mem_wr_data` = 0.
  - `words_loaded` = 0.
- `rst` mid-load: everything returns to reset values at the next edge. A partially assembled word is discarded and never written.
- Write latency: `mem_byte_w_en` = 4'b1111 for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `mem_wr_addr` and `mem_wr_data` are valid in that same cycle.
- Back-to-back bytes: one byte per cycle sustained. A write pulse may coincide with acceptance of the next word's byte 0.
- Release:
  - `cpu_rst` falls and `done` rises in the cycle after the last write pulse.
  - With `len == 0`, they change in the cycle after the last header byte.
- ERROR is entered the cycle after the last header byte. `error` is asserted in that cycle.
- `reload` and `rst` in the same cycle: `rst` wins.

## Structure
- The state encoding (HDR, LOAD, DONE, ERROR) lives in a shared `loader_pkg`, as localparams.
- `WORD_BYTES = 4` also lives in `loader_pkg`.
- One sub-module, `byte_assembler`, is natural. It shifts in bytes and flags word-complete, and holds a 2-bit byte index.
- The FSM, counters and the write register stay in `program_loader`.

## Test plan
- **Basic load:** stream `02 00 | 13 00 00 00 | 93 00 10 00` back-to-back.
  - Writes 0x00000013 @0x000, then 0x00100093 @0x004.
  - `cpu_rst` falls one cycle after the second write pulse.
  - `words_loaded` = 2.
- **Gapped input:** same stream with random `rx_valid` gaps, including one inside a word.
  - Identical writes.
  - No write pulse until the 4th byte is accepted.
- **Zero length:** `00 00`.
  - No writes.
  - `done` = 1 and `cpu_rst` = 0 one cycle after the 2nd byte.
- **Overflow:** `01 04` (1025 > 1024 for `ADDR_WIDTH=12`).
  - ERROR; `error` = 1; `cpu_rst` stays 1.
  - `rx_ready` = 0; no writes.
- **Reset mid-load:** header `03 00` plus 6 word bytes, then `rst` for 1 cycle.
  - Only word 0 is written.
  - All outputs return to reset values.
  - A fresh `01 00 AA BB CC DD` writes 0xDDCCBBAA @0x000.
- **Reload:** after a DONE, pulse `reload`, then send `01 00 EF BE AD DE`.
  - `cpu_rst` = 1 the cycle after `reload`.
  - 0xDEADBEEF @0x000.
  - `cpu_rst` falls again.
  - `reload` pulsed during LOAD has no effect.
